// File: rtl/fir_adder_tree_pipe.sv
// Pipelined FIR accumulator: sums TAPS signed products through a registered
// binary adder tree, then rounds (half-up), shifts and narrows the result with
// optional saturation. One vector per clock; a valid bit travels with the data.
module fir_adder_tree_pipe #(
  parameter int TAPS     = 401,
  parameter int MULTBITS = 32,
  parameter int OUTBITS  = 24,
  parameter int SHIFT    = 16,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [MULTBITS-1:0] multiplier_out [0:TAPS-1],
  output logic                       out_valid,
  output logic signed [OUTBITS-1:0]  out,
  output logic                       out_ovf
);

  localparam int LEVELS   = $clog2(TAPS);
  localparam int P        = 1 << LEVELS;
  localparam int ACCUBITS = MULTBITS + LEVELS;
  localparam int LATENCY  = LEVELS + 1;
  localparam int RB       = ACCUBITS + 1;

  // Rounding constant: half of one output LSB, so the shift rounds toward +inf.
  localparam int                     RPOS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RB-1:0]   RND  = (SHIFT > 0) ? (RB'(1) << RPOS) : '0;
  localparam logic signed [OUTBITS-1:0] OUT_MAX = {1'b0, {(OUTBITS-1){1'b1}}};
  localparam logic signed [OUTBITS-1:0] OUT_MIN = {1'b1, {(OUTBITS-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Valid pipeline: vin[s] is the valid bit arriving at stage s; stages
  // 0..LEVELS-1 are tree levels, stage LEVELS is the output register.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vin;

  if (LATENCY == 1) begin : g_vin_single
    assign vin = in_valid;
  end else begin : g_vin_chain
    assign vin = {vld_q[LATENCY-2:0], in_valid};
  end

  // Shift the valid bit one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every stage samples pre-edge values;
    // blocking = here would let a valid bit ripple through several stages at once.
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vin;
  end

  assign out_valid = vld_q[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Leaves: sign-extend products to ACCUBITS, zero-pad up to P leaves.
  // ---------------------------------------------------------------------------
  logic signed [ACCUBITS-1:0] leaf [0:P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < TAPS) begin : g_prod
      assign leaf[i] = ACCUBITS'(multiplier_out[i]);
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree in heap order: node n sums children 2n and 2n+1; indices >= P
  // are leaves. Node n sits at depth floor(log2 n), registered at stage
  // LEVELS-1-depth, so leaf parents load on in_valid and the root last.
  // ---------------------------------------------------------------------------
  logic signed [ACCUBITS-1:0] root;

  if (LEVELS == 0) begin : g_no_tree
    assign root = leaf[0];
  end else begin : g_tree
    logic signed [ACCUBITS-1:0] node_q [1:P-1];

    for (genvar n = 1; n < P; n++) begin : g_node
      localparam int DEPTH = $clog2(n + 1) - 1;
      localparam int STAGE = LEVELS - DEPTH - 1;
      logic signed [ACCUBITS-1:0] lhs;
      logic signed [ACCUBITS-1:0] rhs;

      if (2 * n >= P) begin : g_from_leaf
        assign lhs = leaf[2*n-P];
        assign rhs = leaf[2*n+1-P];
      end else begin : g_from_node
        assign lhs = node_q[2*n];
        assign rhs = node_q[2*n+1];
      end

      // Register the pairwise sum when this level's incoming data is valid.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the tree registers are reset along with the valid bits so a
        // mid-stream reset leaves no partial sums behind in any stage.
        if (!rst_n)           node_q[n] <= '0;
        else if (vin[STAGE])  node_q[n] <= lhs + rhs;
      end
    end

    assign root = node_q[1];
  end

  // ---------------------------------------------------------------------------
  // Output stage: round half-up, arithmetic shift, then saturate or wrap.
  // ---------------------------------------------------------------------------
  logic signed [RB-1:0]      rnd_sum;
  logic signed [RB-1:0]      shifted;
  logic [RB-OUTBITS:0]       top_bits;
  logic                      fits;
  logic signed [OUTBITS-1:0] out_d;
  logic                      ovf_d;
  logic signed [OUTBITS-1:0] out_q;
  logic                      ovf_q;

  // Compute the narrowed result and its overflow flag for the output register.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition,
    // otherwise the conditional saturation override would infer a latch.
    rnd_sum  = RB'(root) + RND;
    shifted  = rnd_sum >>> SHIFT;
    top_bits = shifted[RB-1:OUTBITS-1];
    fits     = (&top_bits) | ~(|top_bits);
    ovf_d    = ~fits;
    out_d    = shifted[OUTBITS-1:0];
    if (SATURATE != 0 && !fits) out_d = shifted[RB-1] ? OUT_MIN : OUT_MAX;
  end

  // Capture the result when valid data reaches the last stage; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (vin[LATENCY-1]) begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out     = out_q;
  assign out_ovf = ovf_q;

endmodule
